// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one WIDTH-bit adder.
// A single result register sits behind the adder. A valid/ready handshake on
// both sides lets the block deliver one result per cycle.
`timescale 1ns/1ps
module shared_adder_arbiter #(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_carry,
    output logic [ID_W-1:0]          res_id,
    input  logic                     res_ready
);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_next;
    logic               slot_free;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     sum_full;

    // The result register can take a new result if it is empty or being drained now.
    assign slot_free = !res_valid || res_ready;

    // Round-robin search that starts at ptr and wraps modulo NUM_REQ.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt       = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (slot_free && !gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
                gnt[idx]  = 1'b1;
            end
        end
    end

    // Reset also gates the grant, so req_ready drops at once when rst_n goes low.
    assign req_ready = rst_n ? gnt : '0;
    assign accept    = |req_ready;

    // The grant steers the operand mux that feeds the one shared adder.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                op_a = req_a[i*WIDTH +: WIDTH];
                op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum_full = {1'b0, op_a} + {1'b0, op_b};
    assign ptr_next = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);

    // Result register and arbitration pointer. A new result has priority over draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_sum   <= sum_full[WIDTH-1:0];
            res_carry <= sum_full[WIDTH];
            res_id    <= gnt_idx;
            ptr       <= ptr_next;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Self-checking bench for shared_adder_arbiter. Directed scenarios run first,
// then randomized traffic, all scored against a round-robin reference model.
`timescale 1ns/1ps
module tb_shared_adder_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        carry;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     res_valid;
    logic [WIDTH-1:0]         res_sum;
    logic                     res_carry;
    logic [1:0]               res_id;
    logic                     res_ready;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic m_valid;
    int   m_ptr;
    int   wait_cnt[NUM_REQ];
    int   last_gnt;

    shared_adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .res_valid(res_valid), .res_sum(res_sum),
        .res_carry(res_carry), .res_id(res_id), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_valid  = 1'b0;
        m_ptr    = 0;
        last_gnt = -1;
        for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    endtask

    // Stimulus side: predict the grant from the arbitration rules and queue the expected result.
    task automatic step();
        logic [NUM_REQ-1:0] exp_gnt;
        logic [32:0]        full;
        int                 gid;
        @(negedge clk);
        #1;
        exp_gnt = '0;
        gid     = -1;
        if (!m_valid || res_ready) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NUM_REQ;
                if (gid < 0 && req_valid[idx]) gid = idx;
            end
        end
        if (gid >= 0) exp_gnt[gid] = 1'b1;
        check("req_ready", {60'd0, req_ready}, {60'd0, exp_gnt});
        if (gid >= 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == gid) begin
                    check("starvation", 64'(wait_cnt[i] < NUM_REQ), 64'd1);
                    wait_cnt[i] = 0;
                end else if (req_valid[i]) begin
                    wait_cnt[i]++;
                end else begin
                    wait_cnt[i] = 0;
                end
            end
            full = {1'b0, req_a[gid*WIDTH +: WIDTH]} + {1'b0, req_b[gid*WIDTH +: WIDTH]};
            q.push_back('{id: 2'(gid), sum: full[31:0], carry: full[32]});
            m_ptr = (gid + 1) % NUM_REQ;
        end
        if (gid >= 0) m_valid = 1'b1;
        else if (res_ready) m_valid = 1'b0;
        last_gnt = gid;
        @(posedge clk);
        #1;
    endtask

    // Monitor side: compare every presented result against the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("res_valid", {63'd0, res_valid}, {63'd0, m_valid});
            if (res_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_extra: got result id=%0d sum=0x%0h with nothing expected", res_id, res_sum);
                end else begin
                    check("res_id", {62'd0, res_id}, {62'd0, q[0].id});
                    check("res_sum", {32'd0, res_sum}, {32'd0, q[0].sum});
                    check("res_carry", {63'd0, res_carry}, {63'd0, q[0].carry});
                    if (res_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        model_clear();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    initial begin
        logic [31:0] held_sum;
        rst_n = 1'b0; req_valid = 4'hF; req_a = '0; req_b = '0; res_ready = 1'b0;
        model_clear();
        #3;
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_sum", {32'd0, res_sum}, 64'd0);
        check("rst_res_carry", {63'd0, res_carry}, 64'd0);
        check("rst_res_id", {62'd0, res_id}, 64'd0);
        check("rst_req_ready", {60'd0, req_ready}, 64'd0);
        do_reset();

        // Single request from requester 2.
        set_ops(2, 32'h5, 32'h7); req_valid = 4'b0100; res_ready = 1'b1;
        #1 check("single_gnt", {60'd0, req_ready}, 64'b0100);
        step();
        check("single_sum", {32'd0, res_sum}, 64'hC);
        check("single_id", {62'd0, res_id}, 64'd2);
        req_valid = '0; step();

        // Carry-out on overflow.
        set_ops(0, 32'hFFFF_FFFF, 32'h1); req_valid = 4'b0001;
        step();
        check("ovf_sum", {32'd0, res_sum}, 64'd0);
        check("ovf_carry", {63'd0, res_carry}, 64'd1);
        req_valid = '0; step();

        // Round-robin with every requester asking continuously.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, $urandom, $urandom);
        req_valid = 4'hF; res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_gnt", {60'd0, req_ready}, 64'(1 << (k % 4)));
            step();
            check("rr_id", {62'd0, res_id}, 64'(k % 4));
            check("rr_valid", {63'd0, res_valid}, 64'd1);
        end

        // Backpressure: result held, grants blocked, then full-throughput resume.
        do_reset();
        set_ops(1, 32'h1234_0000, 32'h0000_5678); req_valid = 4'b0010; res_ready = 1'b0;
        step();
        held_sum = res_sum;
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_gnt", {60'd0, req_ready}, 64'd0);
            step();
            check("bp_hold", {32'd0, res_sum}, {32'd0, held_sum});
        end
        res_ready = 1'b1;
        #1 check("bp_resume_gnt", {60'd0, req_ready}, 64'b0010);
        step();
        check("bp_no_gap", {63'd0, res_valid}, 64'd1);
        req_valid = '0; step();

        // Reset asserted while a result is pending.
        req_valid = 4'b0010; res_ready = 1'b0; step();
        req_valid = 4'b1001;
        #2 rst_n = 1'b0;
        #1 check("mid_rst_valid", {63'd0, res_valid}, 64'd0);
        check("mid_rst_ready", {60'd0, req_ready}, 64'd0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1; res_ready = 1'b1;
        #1 check("post_rst_gnt", {60'd0, req_ready}, 64'b0001);
        step();
        req_valid = '0; step();

        // Randomized traffic; a requester keeps valid and operands until it is granted.
        for (int c = 0; c < 20000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || last_gnt == i) begin
                    req_valid[i] = $urandom_range(1, 0) == 1;
                    if ($urandom_range(7, 0) == 0) set_ops(i, 32'hFFFF_FFFF, $urandom_range(3, 0));
                    else set_ops(i, $urandom, $urandom);
                end
            end
            res_ready = $urandom_range(9, 0) < 7;
            step();
        end

        req_valid = '0; res_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
